// File: rtl/moore_pkg.sv
// Shared types for the 1011 Moore sequence detector.
// State encoding is visible on the debug port, so values are fixed.
package moore_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4
    } state_t;

    localparam int PATTERN_LEN = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating hit counter with a sticky overflow flag.
// Clear wins over a simultaneous increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         ovf
);

    logic [W:0] sum;

    // The carry out of the widened add marks the all-ones case.
    assign sum = {1'b0, cnt} + {{W{1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (inc) begin
            if (sum[W]) begin
                ovf <= 1'b1;
            end else begin
                cnt <= sum[W-1:0];
            end
        end
    end

endmodule

// File: rtl/moore_seq_detector.sv
// Serial 1011 pattern detector (Moore FSM) with a saturating hit count.
// detect is registered alongside the state, so no din path reaches it.
module moore_seq_detector
    import moore_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter bit OVERLAP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             clr_cnt,
    output logic             detect,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] hit_count,
    output logic             overflow
);

    state_t cur;
    state_t nxt;
    logic   legal;
    logic   hit;

    always_comb begin
        nxt   = IDLE;
        legal = 1'b1;
        case (cur)
            IDLE:    nxt = din ? S1 : IDLE;
            S1:      nxt = din ? S1 : S10;
            S10:     nxt = din ? S101 : IDLE;
            S101:    nxt = din ? S1011 : S10;
            S1011: begin
                if (din) nxt = S1;
                else     nxt = OVERLAP ? S10 : IDLE;
            end
            default: legal = 1'b0;
        endcase
    end

    assign hit = din_valid && legal && (cur != S1011) && (nxt == S1011);

    // Illegal codes recover to IDLE even without a valid bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur    <= IDLE;
            detect <= 1'b0;
        end else if (!legal) begin
            cur    <= IDLE;
            detect <= 1'b0;
        end else if (din_valid) begin
            cur    <= nxt;
            detect <= (nxt == S1011);
        end
    end

    assign state = cur;

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk(clk),
        .rst(rst),
        .inc(hit),
        .clr(clr_cnt),
        .cnt(hit_count),
        .ovf(overflow)
    );

endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed bench: three detector variants share one stimulus stream.
// a: CNT_W=8 overlap, b: CNT_W=8 no overlap, c: CNT_W=2 overlap.
module tb_moore_seq_detector;

    logic       clk;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       clr_cnt;

    logic       det_a, det_b, det_c;
    logic [2:0] st_a, st_b, st_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic       ovf_a, ovf_b, ovf_c;

    int n_tests;
    int n_fail;

    moore_seq_detector #(.CNT_W(8), .OVERLAP(1'b1)) dut_a (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .clr_cnt(clr_cnt), .detect(det_a), .state(st_a),
        .hit_count(cnt_a), .overflow(ovf_a)
    );

    moore_seq_detector #(.CNT_W(8), .OVERLAP(1'b0)) dut_b (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .clr_cnt(clr_cnt), .detect(det_b), .state(st_b),
        .hit_count(cnt_b), .overflow(ovf_b)
    );

    moore_seq_detector #(.CNT_W(2), .OVERLAP(1'b1)) dut_c (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .clr_cnt(clr_cnt), .detect(det_c), .state(st_c),
        .hit_count(cnt_c), .overflow(ovf_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge with the given inputs; returns 1 time unit after it.
    task automatic step(input logic b, input logic v, input logic c);
        din       = b;
        din_valid = v;
        clr_cnt   = c;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        clr_cnt   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_match_tail();
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        din       = 1'b0;
        din_valid = 1'b0;
        clr_cnt   = 1'b0;

        // Reset state
        do_reset();
        check("rst_state", 32'(st_a), 0);
        check("rst_detect", 32'(det_a), 0);
        check("rst_count", 32'(cnt_a), 0);
        check("rst_ovf", 32'(ovf_a), 0);

        // Basic 1011
        step(1'b1, 1'b1, 1'b0);
        check("b1_state", 32'(st_a), 1);
        step(1'b0, 1'b1, 1'b0);
        check("b2_state", 32'(st_a), 2);
        step(1'b1, 1'b1, 1'b0);
        check("b3_state", 32'(st_a), 3);
        check("b3_detect", 32'(det_a), 0);
        step(1'b1, 1'b1, 1'b0);
        check("b4_detect", 32'(det_a), 1);
        check("b4_state", 32'(st_a), 4);
        check("b4_count", 32'(cnt_a), 1);
        check("b4_detect_nov", 32'(det_b), 1);

        // Overlap vs restart: continue with 0,1,1
        step(1'b0, 1'b1, 1'b0);
        check("ov_b5_state", 32'(st_a), 2);
        check("ov_b5_detect", 32'(det_a), 0);
        check("nov_b5_state", 32'(st_b), 0);
        step(1'b1, 1'b1, 1'b0);
        check("ov_b6_state", 32'(st_a), 3);
        check("nov_b6_state", 32'(st_b), 1);
        step(1'b1, 1'b1, 1'b0);
        check("ov_b7_detect", 32'(det_a), 1);
        check("ov_b7_count", 32'(cnt_a), 2);
        check("nov_b7_state", 32'(st_b), 1);
        check("nov_b7_detect", 32'(det_b), 0);
        check("nov_b7_count", 32'(cnt_b), 1);

        // Stall with din_valid low
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(i[0], 1'b0, 1'b0);
            check("stall_state", 32'(st_a), 3);
            check("stall_detect", 32'(det_a), 0);
        end
        step(1'b1, 1'b1, 1'b0);
        check("stall_end_detect", 32'(det_a), 1);
        check("stall_end_count", 32'(cnt_a), 1);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b0);
            check("hold_detect", 32'(det_a), 1);
            check("hold_count", 32'(cnt_a), 1);
        end

        // Saturation on the 2-bit counter
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        send_match_tail();
        check("sat1_count", 32'(cnt_c), 1);
        check("sat1_ovf", 32'(ovf_c), 0);
        send_match_tail();
        check("sat2_count", 32'(cnt_c), 2);
        send_match_tail();
        check("sat3_count", 32'(cnt_c), 3);
        check("sat3_ovf", 32'(ovf_c), 0);
        send_match_tail();
        check("sat4_count", 32'(cnt_c), 3);
        check("sat4_ovf", 32'(ovf_c), 1);
        check("sat4_wide_count", 32'(cnt_a), 4);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("clr_count", 32'(cnt_c), 0);
        check("clr_ovf", 32'(ovf_c), 0);
        check("clr_state", 32'(st_c), 4);
        check("clr_detect", 32'(det_c), 1);
        step(1'b0, 1'b0, 1'b0);
        check("clr_ovf_stays", 32'(ovf_c), 0);

        // Async reset from S101 with count 5
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        send_match_tail();
        for (int i = 0; i < 4; i++) send_match_tail();
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("pre_arst_state", 32'(st_a), 3);
        check("pre_arst_count", 32'(cnt_a), 5);
        #2;
        rst = 1'b1;
        #1;
        check("arst_state", 32'(st_a), 0);
        check("arst_detect", 32'(det_a), 0);
        check("arst_count", 32'(cnt_a), 0);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        check("post_arst_zero", 32'(st_a), 0);
        step(1'b1, 1'b1, 1'b0);
        check("post_arst_one", 32'(st_a), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
